// File: rtl/cv32e40p_hwloop_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_hwloop_pkg
// Shared definitions for the hardware-loop block permuter and block sequencer.
//   hwloop_seq_state_e : block sequencer FSM states
//   HWLP_NUM_BLOCK     : number of independent blocks in a loop body
//   HWLP_IDX_WIDTH     : width of one block index in the permutation vector
// ----------------------------------------------------------------------------
package cv32e40p_hwloop_pkg;

  localparam int unsigned HWLP_NUM_BLOCK = 4;
  localparam int unsigned HWLP_IDX_WIDTH = $clog2(HWLP_NUM_BLOCK);

  // IDLE: not in a loop. WAIT: permuter is advancing, jump to the first
  // block of the iteration. RUN: executing blocks in permuted order.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } hwloop_seq_state_e;

endpackage

// File: rtl/cv32e40p_hwloop_block_match.sv
// ----------------------------------------------------------------------------
// cv32e40p_hwloop_block_match
// Address datapath of the block sequencer. Detects retirement of the last
// instruction of the block at the current position and selects the start
// addresses the sequencer may jump to.
//   block_start_i / block_end_i : flat per-block address tables (block 0 in LSBs)
//   order_i        : latched permutation, entry k = block executed at position k
//   pos_i          : current position within the iteration
//   first_idx_i    : block index that opens the next iteration
//   instr_valid_i, pc_id_i : retiring ID-stage instruction
//   hit_o          : current block's last instruction retires this cycle
//   next_start_o   : start address of the block at position pos_i+1
//   first_start_o  : start address of block first_idx_i
// ----------------------------------------------------------------------------
module cv32e40p_hwloop_block_match
  import cv32e40p_hwloop_pkg::*;
#(
  parameter int unsigned NUM_BLOCK  = HWLP_NUM_BLOCK,
  parameter int unsigned IDX_WIDTH  = HWLP_IDX_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [NUM_BLOCK*ADDR_WIDTH-1:0] block_start_i,
  input  logic [NUM_BLOCK*ADDR_WIDTH-1:0] block_end_i,
  input  logic [NUM_BLOCK*IDX_WIDTH-1:0]  order_i,
  input  logic [IDX_WIDTH-1:0]            pos_i,
  input  logic [IDX_WIDTH-1:0]            first_idx_i,
  input  logic                            instr_valid_i,
  input  logic [ADDR_WIDTH-1:0]           pc_id_i,
  output logic                            hit_o,
  output logic [ADDR_WIDTH-1:0]           next_start_o,
  output logic [ADDR_WIDTH-1:0]           first_start_o
);

  logic [ADDR_WIDTH-1:0] start_a [NUM_BLOCK];
  logic [ADDR_WIDTH-1:0] end_a   [NUM_BLOCK];
  logic [IDX_WIDTH-1:0]  order_a [NUM_BLOCK];

  for (genvar g = 0; g < NUM_BLOCK; g++) begin : g_unpack
    assign start_a[g] = block_start_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign end_a[g]   = block_end_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign order_a[g] = order_i[g*IDX_WIDTH +: IDX_WIDTH];
  end

  // pos_next wraps at the last position; the sequencer never uses
  // next_start_o there because the iteration ends instead.
  logic [IDX_WIDTH-1:0] pos_next;
  logic [IDX_WIDTH-1:0] cur_blk;
  logic [IDX_WIDTH-1:0] nxt_blk;

  assign pos_next = pos_i + IDX_WIDTH'(1);
  assign cur_blk  = order_a[pos_i];
  assign nxt_blk  = order_a[pos_next];

  assign hit_o         = instr_valid_i && (pc_id_i == end_a[cur_blk]);
  assign next_start_o  = start_a[nxt_blk];
  assign first_start_o = start_a[first_idx_i];

endmodule

// File: rtl/cv32e40p_hwloop_block_sequencer.sv
// ----------------------------------------------------------------------------
// cv32e40p_hwloop_block_sequencer
// Runs a hardware-loop body split into NUM_BLOCK blocks, in the order given
// by the permuter, for iter_count_i iterations, then exits to exit_addr_i.
//   clk, rst_n        : clock, synchronous active-low reset
//   start_i           : arm the loop (IDLE only); iter_count_i sampled with it
//   abort_i           : cancel the loop (flush/exception)
//   block_start_i/end_i, exit_addr_i : address tables, held stable by caller
//   index_i / next_o  : permutation from / advance request to the permuter
//   instr_valid_i, pc_id_i : retiring ID-stage instruction
//   jump_o, jump_target_o  : one-cycle PC-mux jump request (target 0 otherwise)
//   active_o          : sequencer owns control flow
//   done_o            : one-cycle pulse on completion or abort
// ----------------------------------------------------------------------------
module cv32e40p_hwloop_block_sequencer
  import cv32e40p_hwloop_pkg::*;
#(
  parameter int unsigned NUM_BLOCK  = HWLP_NUM_BLOCK,
  parameter int unsigned IDX_WIDTH  = HWLP_IDX_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [NUM_BLOCK*ADDR_WIDTH-1:0] block_start_i,
  input  logic [NUM_BLOCK*ADDR_WIDTH-1:0] block_end_i,
  input  logic [ADDR_WIDTH-1:0]           exit_addr_i,
  input  logic [CNT_WIDTH-1:0]            iter_count_i,
  input  logic [NUM_BLOCK*IDX_WIDTH-1:0]  index_i,
  output logic                            next_o,
  input  logic                            instr_valid_i,
  input  logic [ADDR_WIDTH-1:0]           pc_id_i,
  output logic                            jump_o,
  output logic [ADDR_WIDTH-1:0]           jump_target_o,
  output logic                            active_o,
  output logic                            done_o
);

  localparam logic [IDX_WIDTH-1:0] LAST_POS = IDX_WIDTH'(NUM_BLOCK - 1);

  hwloop_seq_state_e              state_q, state_d;
  logic [IDX_WIDTH-1:0]           pos_q, pos_d;
  logic [CNT_WIDTH-1:0]           remaining_q, remaining_d;
  logic [NUM_BLOCK*IDX_WIDTH-1:0] order_q, order_d;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] next_start;
  logic [ADDR_WIDTH-1:0] first_start;

  cv32e40p_hwloop_block_match #(
    .NUM_BLOCK  (NUM_BLOCK),
    .IDX_WIDTH  (IDX_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_block_match (
    .block_start_i (block_start_i),
    .block_end_i   (block_end_i),
    .order_i       (order_q),
    .pos_i         (pos_q),
    .first_idx_i   (index_i[IDX_WIDTH-1:0]),
    .instr_valid_i (instr_valid_i),
    .pc_id_i       (pc_id_i),
    .hit_o         (hit),
    .next_start_o  (next_start),
    .first_start_o (first_start)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      remaining_q <= '0;
      order_q     <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      remaining_q <= remaining_d;
      order_q     <= order_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    pos_d         = pos_q;
    remaining_d   = remaining_q;
    order_d       = order_q;
    next_o        = 1'b0;
    jump_o        = 1'b0;
    jump_target_o = '0;
    done_o        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (iter_count_i != '0) begin
            next_o      = 1'b1;
            remaining_d = iter_count_i;
            state_d     = WAIT;
          end else begin
            // Zero-trip loop: skip the body entirely.
            jump_o        = 1'b1;
            jump_target_o = exit_addr_i;
            done_o        = 1'b1;
          end
        end
      end

      WAIT: begin
        if (abort_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else begin
          // index_i was advanced by the permuter on the previous edge.
          order_d       = index_i;
          pos_d         = '0;
          jump_o        = 1'b1;
          jump_target_o = first_start;
          state_d       = RUN;
        end
      end

      RUN: begin
        if (abort_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else if (hit) begin
          if (pos_q != LAST_POS) begin
            jump_o        = 1'b1;
            jump_target_o = next_start;
            pos_d         = pos_q + IDX_WIDTH'(1);
          end else if (remaining_q > CNT_WIDTH'(1)) begin
            // The jump to the next iteration's first block is issued from
            // WAIT once the permuter has produced the new order.
            remaining_d = remaining_q - CNT_WIDTH'(1);
            next_o      = 1'b1;
            state_d     = WAIT;
          end else begin
            remaining_d   = '0;
            jump_o        = 1'b1;
            jump_target_o = exit_addr_i;
            done_o        = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign active_o = (state_q != IDLE);

endmodule

// File: tb/tb_cv32e40p_hwloop_block_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_hwloop_block_sequencer
// Scoreboard bench: stimulus pushes the expected {jump, target, next, done}
// event for each cycle in which the sequencer should act; a monitor pops and
// compares whenever the DUT drives jump_o, next_o or done_o.
// ----------------------------------------------------------------------------
module tb_cv32e40p_hwloop_block_sequencer;
  import cv32e40p_hwloop_pkg::*;

  localparam int NB = 4;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int CW = 32;
  localparam logic [AW-1:0] EXIT = 32'h200;

  typedef struct packed {
    logic          jump;
    logic [AW-1:0] tgt;
    logic          nxt;
    logic          done;
  } evt_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic              abort_i;
  logic [NB*AW-1:0]  block_start_i;
  logic [NB*AW-1:0]  block_end_i;
  logic [AW-1:0]     exit_addr_i;
  logic [CW-1:0]     iter_count_i;
  logic [NB*IW-1:0]  index_i;
  logic              next_o;
  logic              instr_valid_i;
  logic [AW-1:0]     pc_id_i;
  logic              jump_o;
  logic [AW-1:0]     jump_target_o;
  logic              active_o;
  logic              done_o;

  always #5 clk = ~clk;

  cv32e40p_hwloop_block_sequencer #(
    .NUM_BLOCK (NB), .IDX_WIDTH (IW), .ADDR_WIDTH (AW), .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .block_start_i (block_start_i),
    .block_end_i   (block_end_i),
    .exit_addr_i   (exit_addr_i),
    .iter_count_i  (iter_count_i),
    .index_i       (index_i),
    .next_o        (next_o),
    .instr_valid_i (instr_valid_i),
    .pc_id_i       (pc_id_i),
    .jump_o        (jump_o),
    .jump_target_o (jump_target_o),
    .active_o      (active_o),
    .done_o        (done_o)
  );

  evt_t             sb_q[$];
  logic [NB*IW-1:0] perm_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_next_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] bstart(input int k);
    return AW'(32'h100 + 32'h10 * k);
  endfunction

  function automatic logic [AW-1:0] bend(input int k);
    return bstart(k) + AW'(32'hC);
  endfunction

  function automatic int ordv(input logic [NB*IW-1:0] p, input int k);
    return int'(p[k*IW +: IW]);
  endfunction

  // Permuter model: registered index vector, advances one edge after next_o.
  always @(posedge clk) begin
    if (!rst_n) index_i <= '0;
    else if (next_o && perm_q.size() > 0) index_i <= perm_q.pop_front();
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    evt_t act;
    evt_t e;
    if (jump_o || next_o || done_o) begin
      act = '{jump_o, jump_target_o, next_o, done_o};
      if (next_o) n_next_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_event", 64'(act), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("event", 64'(act), 64'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic j, input logic [AW-1:0] t, input logic n, input logic d);
    evt_t e;
    e = '{j, t, n, d};
    sb_q.push_back(e);
  endtask

  task automatic start_loop(input int iters);
    start_i      = 1'b1;
    iter_count_i = CW'(iters);
    if (iters != 0) push(1'b0, '0, 1'b1, 1'b0);
    else            push(1'b1, EXIT, 1'b0, 1'b1);
    cyc();
    start_i = 1'b0;
  endtask

  task automatic wait_cycle(input logic [NB*IW-1:0] p);
    push(1'b1, bstart(ordv(p, 0)), 1'b0, 1'b0);
    cyc();
  endtask

  // Retire the end of blocks at positions [from, to) of order p.
  task automatic hits(input logic [NB*IW-1:0] p, input int from, input int to, input bit last);
    for (int k = from; k < to; k++) begin
      pc_id_i       = bend(ordv(p, k));
      instr_valid_i = 1'b1;
      if (k < NB - 1) push(1'b1, bstart(ordv(p, k + 1)), 1'b0, 1'b0);
      else if (last)  push(1'b1, EXIT, 1'b0, 1'b1);
      else            push(1'b0, '0, 1'b1, 1'b0);
      cyc();
      instr_valid_i = 1'b0;
    end
  endtask

  task automatic run_iter(input logic [NB*IW-1:0] p, input bit last);
    wait_cycle(p);
    hits(p, 0, NB, last);
  endtask

  // Orders (position 0 in LSBs).
  localparam logic [NB*IW-1:0] PA  = 8'b11_00_01_10; // 2,1,0,3
  localparam logic [NB*IW-1:0] PB1 = 8'b10_00_11_01; // 1,3,0,2
  localparam logic [NB*IW-1:0] PB2 = 8'b00_01_10_11; // 3,2,1,0
  localparam logic [NB*IW-1:0] PB3 = 8'b11_10_01_00; // 0,1,2,3

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    exit_addr_i   = EXIT;
    iter_count_i  = '0;
    instr_valid_i = 1'b0;
    pc_id_i       = '0;
    for (int k = 0; k < NB; k++) begin
      block_start_i[k*AW +: AW] = bstart(k);
      block_end_i[k*AW +: AW]   = bend(k);
    end
    cyc();
    cyc();
    rst_n = 1'b1;

    check("rst_next",   64'(next_o), 64'(0));
    check("rst_jump",   64'(jump_o), 64'(0));
    check("rst_target", 64'(jump_target_o), 64'(0));
    check("rst_done",   64'(done_o), 64'(0));
    check("rst_active", 64'(active_o), 64'(0));

    // Single iteration: 0x120, 0x110, 0x100, 0x130, exit.
    perm_q.push_back(PA);
    n_next_seen = 0;
    start_loop(1);
    check("a_active", 64'(active_o), 64'(1));
    run_iter(PA, 1'b1);
    check("a_next_count", 64'(n_next_seen), 64'(1));
    check("a_idle", 64'(active_o), 64'(0));

    // Three iterations, new permutation each time.
    perm_q.push_back(PB1);
    perm_q.push_back(PB2);
    perm_q.push_back(PB3);
    n_next_seen = 0;
    start_loop(3);
    run_iter(PB1, 1'b0);
    run_iter(PB2, 1'b0);
    run_iter(PB3, 1'b1);
    check("b_next_count", 64'(n_next_seen), 64'(3));
    check("b_idle", 64'(active_o), 64'(0));

    // Zero-trip loop.
    n_next_seen = 0;
    start_loop(0);
    check("c_idle", 64'(active_o), 64'(0));
    check("c_next_count", 64'(n_next_seen), 64'(0));

    // Abort at pos 1 together with a block-end hit; start_i in RUN ignored.
    perm_q.push_back(PA);
    start_loop(2);
    wait_cycle(PA);
    hits(PA, 0, 1, 1'b0);
    start_i      = 1'b1;
    iter_count_i = '0;
    cyc();
    start_i = 1'b0;
    check("d_active_after_start", 64'(active_o), 64'(1));
    pc_id_i       = bend(ordv(PA, 1));
    instr_valid_i = 1'b1;
    abort_i       = 1'b1;
    push(1'b0, '0, 1'b0, 1'b1);
    cyc();
    abort_i       = 1'b0;
    instr_valid_i = 1'b0;
    check("d_idle", 64'(active_o), 64'(0));

    // instr_valid_i gating, then a non-matching valid PC, then the real hit.
    perm_q.push_back(PB2);
    start_loop(1);
    wait_cycle(PB2);
    pc_id_i       = bend(ordv(PB2, 0));
    instr_valid_i = 1'b0;
    repeat (5) cyc();
    check("e_active_hold", 64'(active_o), 64'(1));
    pc_id_i       = bend(ordv(PB2, 0)) + AW'(4);
    instr_valid_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0;
    hits(PB2, 0, NB, 1'b1);
    check("e_idle", 64'(active_o), 64'(0));

    // Synchronous reset while in RUN at pos 2.
    perm_q.push_back(PA);
    start_loop(1);
    wait_cycle(PA);
    hits(PA, 0, 2, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("f_next",   64'(next_o), 64'(0));
    check("f_jump",   64'(jump_o), 64'(0));
    check("f_target", 64'(jump_target_o), 64'(0));
    check("f_done",   64'(done_o), 64'(0));
    check("f_active", 64'(active_o), 64'(0));
    // A block-end retiring while IDLE does nothing.
    pc_id_i       = bend(ordv(PA, 2));
    instr_valid_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0;
    check("f_idle_hit", 64'(active_o), 64'(0));

    cyc();
    cyc();
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    check("perm_empty", 64'(perm_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
